// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// id_ex_operand_stage : ID/EX register with load-use hazard detection and
// MEM/WB operand forwarding to the ALU (forwarding enabled by ID_EX_FWD_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [CW-1:0] i_ALUctrl,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    input  logic [AW-1:0] i_rd,
    input  logic [DW-1:0] i_rdata1,
    input  logic [DW-1:0] i_rdata2,
    input  logic [DW-1:0] i_imm,
    input  logic          i_use_imm,
    input  logic          i_regwrite,
    input  logic          i_memread,
    input  logic          i_flush,
    input  logic [AW-1:0] i_mem_rd,
    input  logic          i_mem_regwrite,
    input  logic [DW-1:0] i_mem_y,
    input  logic [AW-1:0] i_wb_rd,
    input  logic          i_wb_regwrite,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_stall,
    output logic          o_valid,
    output logic [CW-1:0] o_ALUctrl,
    output logic [DW-1:0] o_A,
    output logic [DW-1:0] o_B,
    output logic [DW-1:0] o_store_data,
    output logic [AW-1:0] o_rd,
    output logic          o_regwrite,
    output logic          o_memread
);

    logic          ex_valid;
    logic [CW-1:0] ex_aluctrl;
    logic [AW-1:0] ex_rs1;
    logic [AW-1:0] ex_rs2;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_rdata1;
    logic [DW-1:0] ex_rdata2;
    logic [DW-1:0] ex_imm;
    logic          ex_use_imm;
    logic          ex_regwrite;
    logic          ex_memread;

    logic          stall;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // Flush and stall both collapse to a single all-zero bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid    <= 1'b0;
            ex_aluctrl  <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_use_imm  <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (i_flush || stall) begin
            ex_valid    <= 1'b0;
            ex_aluctrl  <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_use_imm  <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else begin
            ex_valid    <= i_valid;
            ex_aluctrl  <= i_ALUctrl;
            ex_rs1      <= i_rs1;
            ex_rs2      <= i_rs2;
            ex_rd       <= i_rd;
            ex_rdata1   <= i_rdata1;
            ex_rdata2   <= i_rdata2;
            ex_imm      <= i_imm;
            ex_use_imm  <= i_use_imm;
            ex_regwrite <= i_regwrite & i_valid;
            ex_memread  <= i_memread & i_valid;
        end
    end

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be forwarded in time; everything else resolves via MEM/WB.
    assign stall = i_valid & ex_valid & ex_memread & (ex_rd != '0) &
                   ((i_rs1 == ex_rd) | (~i_use_imm & (i_rs2 == ex_rd)));

    always_comb begin
        fwd_a = ex_rdata1;
        if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == ex_rs1))
            fwd_a = i_mem_y;
        else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == ex_rs1))
            fwd_a = i_wb_data;
    end

    always_comb begin
        fwd_b = ex_rdata2;
        if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == ex_rs2))
            fwd_b = i_mem_y;
        else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == ex_rs2))
            fwd_b = i_wb_data;
    end
`else
    logic rs1_raw;
    logic rs2_raw;
    logic unused_nofwd;

    // Without forwarding, wait until the producer has left MEM; the write-through
    // register file covers the WB stage.
    assign rs1_raw = (i_rs1 != '0) &
                     ((ex_valid & ex_regwrite & (ex_rd == i_rs1)) |
                      (i_mem_regwrite & (i_mem_rd == i_rs1)));
    assign rs2_raw = (i_rs2 != '0) &
                     ((ex_valid & ex_regwrite & (ex_rd == i_rs2)) |
                      (i_mem_regwrite & (i_mem_rd == i_rs2)));
    assign stall   = i_valid & (rs1_raw | (~i_use_imm & rs2_raw));

    assign fwd_a = ex_rdata1;
    assign fwd_b = ex_rdata2;

    assign unused_nofwd = ^{i_mem_y, i_wb_rd, i_wb_regwrite, i_wb_data, ex_rs1, ex_rs2};
`endif

    assign o_stall      = stall;
    assign o_valid      = ex_valid;
    assign o_ALUctrl    = ex_aluctrl;
    assign o_A          = fwd_a;
    assign o_B          = ex_use_imm ? ex_imm : fwd_b;
    assign o_store_data = fwd_b;
    assign o_rd         = ex_rd;
    assign o_regwrite   = ex_regwrite;
    assign o_memread    = ex_memread;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// tb_id_ex_operand_stage : directed scenarios plus randomized traffic checked
// against a behavioural model of the ID/EX stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [CW-1:0] alu;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] rdata1, rdata2, imm;
    logic          use_imm, regwrite, memread, flush;
    logic [AW-1:0] mem_rd;
    logic          mem_rw;
    logic [DW-1:0] mem_y;
    logic [AW-1:0] wb_rd;
    logic          wb_rw;
    logic [DW-1:0] wb_data;

    logic          o_stall, o_valid, o_regwrite, o_memread;
    logic [CW-1:0] o_ALUctrl;
    logic [DW-1:0] o_A, o_B, o_store_data;
    logic [AW-1:0] o_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ALUctrl(alu),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_rdata1(rdata1), .i_rdata2(rdata2),
        .i_imm(imm), .i_use_imm(use_imm), .i_regwrite(regwrite), .i_memread(memread),
        .i_flush(flush), .i_mem_rd(mem_rd), .i_mem_regwrite(mem_rw), .i_mem_y(mem_y),
        .i_wb_rd(wb_rd), .i_wb_regwrite(wb_rw), .i_wb_data(wb_data),
        .o_stall(o_stall), .o_valid(o_valid), .o_ALUctrl(o_ALUctrl), .o_A(o_A),
        .o_B(o_B), .o_store_data(o_store_data), .o_rd(o_rd),
        .o_regwrite(o_regwrite), .o_memread(o_memread)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic          v;
        logic [CW-1:0] op;
        logic [AW-1:0] s1, s2, d;
        logic [DW-1:0] r1, r2, im;
        logic          ui, rw, mr;
    } ex_t;
    ex_t m;

    function automatic logic [DW-1:0] model_operand(logic [AW-1:0] src, logic [DW-1:0] rf);
`ifdef ID_EX_FWD_EN
        if (mem_rw && mem_rd != 0 && mem_rd == src) return mem_y;
        if (wb_rw && wb_rd != 0 && wb_rd == src) return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic model_depends(logic [AW-1:0] src);
`ifdef ID_EX_FWD_EN
        return m.v && m.mr && m.d != 0 && m.d == src;
`else
        return src != 0 && ((m.v && m.rw && m.d == src) || (mem_rw && mem_rd == src));
`endif
    endfunction

    function automatic logic model_stall();
        return valid && (model_depends(rs1) || (!use_imm && model_depends(rs2)));
    endfunction

    task automatic clear_inputs();
        valid = 0; alu = 0; rs1 = 0; rs2 = 0; rd = 0; rdata1 = 0; rdata2 = 0;
        imm = 0; use_imm = 0; regwrite = 0; memread = 0; flush = 0;
        mem_rd = 0; mem_rw = 0; mem_y = 0; wb_rd = 0; wb_rw = 0; wb_data = 0;
    endtask

    // Puts an idle (valid=0) instruction into EX and returns just after a negedge.
    task automatic settle();
        @(negedge clk); clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({o_valid, o_ALUctrl, o_A, o_B, o_store_data, o_rd, o_regwrite, o_memread, o_stall} !== '0) begin
            n_fail++; $display("FAIL reset_state: outputs=%h required all zero",
                {o_valid, o_ALUctrl, o_A, o_B, o_store_data, o_rd, o_regwrite, o_memread, o_stall});
        end
        @(negedge clk); rst_n = 1;
        valid = 1; rs1 = 3; rdata1 = 32'h5; alu = 4'h3; regwrite = 1; rd = 2;
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b1 || o_A !== 32'h5) begin
            n_fail++; $display("FAIL reset_preload: valid=%b A=%h required 1/00000005", o_valid, o_A);
        end
        #2; rst_n = 0; #1;
        n_checks++;
        if ({o_valid, o_ALUctrl, o_A, o_rd, o_regwrite, o_stall} !== '0) begin
            n_fail++; $display("FAIL reset_async: valid=%b op=%h A=%h rd=%0d rw=%b stall=%b required all zero",
                o_valid, o_ALUctrl, o_A, o_rd, o_regwrite, o_stall);
        end
        @(negedge clk); rst_n = 1; clear_inputs();
    endtask

    task automatic test_plain_pass();
        settle();
        valid = 1; rs1 = 3; rdata1 = 32'h10; rs2 = 4; rdata2 = 32'h20; alu = 4'd2;
        rd = 6; regwrite = 1;
        @(posedge clk); #1;
        n_checks++;
        if (o_A !== 32'h10 || o_B !== 32'h20 || o_ALUctrl !== 4'd2 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL plain_pass: A=%h B=%h op=%h v=%b required 10/20/2/1",
                o_A, o_B, o_ALUctrl, o_valid);
        end
        n_checks++;
        if (o_store_data !== 32'h20 || o_rd !== 5'd6 || o_regwrite !== 1'b1 || o_memread !== 1'b0) begin
            n_fail++; $display("FAIL plain_ctrl: sd=%h rd=%0d rw=%b mr=%b required 20/6/1/0",
                o_store_data, o_rd, o_regwrite, o_memread);
        end
    endtask

    task automatic test_forward();
        settle();
        valid = 1; rs1 = 5; rdata1 = 32'h1234; rs2 = 5; rdata2 = 32'h5678;
        use_imm = 1; imm = 32'h99;
        @(posedge clk); #1;
        valid = 0; mem_rd = 5; mem_y = 32'hAAAA; mem_rw = 1; wb_rd = 5; wb_data = 32'hBBBB; wb_rw = 1;
        #1;
`ifdef ID_EX_FWD_EN
        n_checks++;
        if (o_A !== 32'hAAAA || o_B !== 32'h99 || o_store_data !== 32'hAAAA) begin
            n_fail++; $display("FAIL fwd_mem_priority: A=%h B=%h sd=%h required AAAA/99/AAAA", o_A, o_B, o_store_data);
        end
        mem_rw = 0; #1;
        n_checks++;
        if (o_A !== 32'hBBBB) begin
            n_fail++; $display("FAIL fwd_wb: A=%h required BBBB", o_A);
        end
`else
        n_checks++;
        if (o_A !== 32'h1234 || o_B !== 32'h99 || o_store_data !== 32'h5678) begin
            n_fail++; $display("FAIL nofwd_regval: A=%h B=%h sd=%h required 1234/99/5678", o_A, o_B, o_store_data);
        end
`endif
        valid = 1; rs1 = 0; rdata1 = 32'h77; use_imm = 0; rs2 = 6; rdata2 = 32'h66;
        mem_rd = 0; mem_rw = 1; wb_rd = 0; wb_rw = 1;
        @(posedge clk); #1;
        n_checks++;
        if (o_A !== 32'h77 || o_B !== 32'h66) begin
            n_fail++; $display("FAIL fwd_r0: A=%h B=%h required 77/66", o_A, o_B);
        end
    endtask

    task automatic test_load_use();
        settle();
        valid = 1; memread = 1; regwrite = 1; rd = 7; rs1 = 1; rs2 = 2; use_imm = 1; alu = 4'd1;
        @(posedge clk); #1;
        memread = 0; rd = 3; alu = 4'd2; rs1 = 8; rs2 = 7; use_imm = 0;
        #1;
        n_checks++;
        if (o_stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: stall=%b required 1", o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_ALUctrl !== 4'd0 || o_memread !== 1'b0 || o_regwrite !== 1'b0) begin
            n_fail++; $display("FAIL load_use_bubble: v=%b op=%h mr=%b rw=%b required 0/0/0/0",
                o_valid, o_ALUctrl, o_memread, o_regwrite);
        end
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_single: stall=%b required 0", o_stall);
        end
        memread = 1; rd = 7; alu = 4'd1; rs1 = 1; rs2 = 2; use_imm = 1;
        @(posedge clk); #1;
        memread = 0; rd = 3; rs1 = 8; rs2 = 7; use_imm = 1; #1;
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_imm: stall=%b required 0", o_stall);
        end
        rs1 = 7; #1;
        n_checks++;
        if (o_stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_rs1: stall=%b required 1", o_stall);
        end
    endtask

    task automatic test_flush();
        settle();
        valid = 1; memread = 1; regwrite = 1; rd = 7; use_imm = 1;
        @(posedge clk); #1;
        memread = 0; rs1 = 7; alu = 4'd5; rd = 4; flush = 1; #1;
        n_checks++;
        if (o_stall !== 1'b1) begin
            n_fail++; $display("FAIL flush_stall: stall=%b required 1", o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_regwrite !== 1'b0 || o_ALUctrl !== 4'd0) begin
            n_fail++; $display("FAIL flush_bubble: v=%b rw=%b op=%h required 0/0/0", o_valid, o_regwrite, o_ALUctrl);
        end
        flush = 0; #1;
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: stall=%b required 0", o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b1 || o_ALUctrl !== 4'd5 || o_regwrite !== 1'b1 || o_rd !== 5'd4) begin
            n_fail++; $display("FAIL flush_resume: v=%b op=%h rw=%b rd=%0d required 1/5/1/4",
                o_valid, o_ALUctrl, o_regwrite, o_rd);
        end
    endtask

    task automatic test_raw_ex();
        settle();
        valid = 1; rd = 9; regwrite = 1; alu = 4'd1; rs1 = 1; rs2 = 2; use_imm = 1;
        @(posedge clk); #1;
        rs1 = 9; rdata1 = 32'h55; rd = 10; alu = 4'd3; #1;
`ifdef ID_EX_FWD_EN
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL raw_fwd_nostall: stall=%b required 0", o_stall);
        end
        @(posedge clk); #1;
        mem_rd = 9; mem_rw = 1; mem_y = 32'hCAFE; #1;
        n_checks++;
        if (o_A !== 32'hCAFE || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL raw_fwd_mem: A=%h v=%b required CAFE/1", o_A, o_valid);
        end
`else
        n_checks++;
        if (o_stall !== 1'b1) begin
            n_fail++; $display("FAIL raw_ex_stall: stall=%b required 1", o_stall);
        end
        @(posedge clk); #1;
        mem_rd = 9; mem_rw = 1; #1;
        n_checks++;
        if (o_stall !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL raw_mem_stall: stall=%b v=%b required 1/0", o_stall, o_valid);
        end
        @(posedge clk); #1;
        mem_rd = 0; mem_rw = 0; wb_rd = 9; wb_rw = 1; wb_data = 32'h99; #1;
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL raw_wb_nostall: stall=%b required 0", o_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (o_valid !== 1'b1 || o_A !== 32'h55 || o_ALUctrl !== 4'd3) begin
            n_fail++; $display("FAIL raw_issue: v=%b A=%h op=%h required 1/55/3", o_valid, o_A, o_ALUctrl);
        end
`endif
    endtask

    task automatic test_random();
        logic          e_stall;
        logic [DW-1:0] e_a, e_b, e_sd;
        settle();
        rst_n = 0; #1; rst_n = 1;
        m = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 0; #1;
                n_checks++;
                if ({o_valid, o_A, o_B, o_regwrite, o_stall} !== '0) begin
                    n_fail++; $display("FAIL rand_midreset: v=%b A=%h B=%h rw=%b stall=%b required zeros",
                        o_valid, o_A, o_B, o_regwrite, o_stall);
                end
                rst_n = 1; m = '0;
            end
            valid    = ($urandom_range(0, 3) != 0);
            alu      = CW'($urandom);
            rs1      = AW'($urandom_range(0, 3));
            rs2      = AW'($urandom_range(0, 3));
            rd       = AW'($urandom_range(0, 3));
            rdata1   = $urandom; rdata2 = $urandom; imm = $urandom;
            use_imm  = $urandom_range(0, 1) == 1;
            regwrite = $urandom_range(0, 1) == 1;
            memread  = $urandom_range(0, 2) == 0;
            flush    = $urandom_range(0, 7) == 0;
            mem_rd   = AW'($urandom_range(0, 3));
            mem_rw   = $urandom_range(0, 1) == 1;
            mem_y    = $urandom;
            wb_rd    = AW'($urandom_range(0, 3));
            wb_rw    = $urandom_range(0, 1) == 1;
            wb_data  = $urandom;
            #1;
            e_stall = model_stall();
            e_a     = model_operand(m.s1, m.r1);
            e_sd    = model_operand(m.s2, m.r2);
            e_b     = m.ui ? m.im : e_sd;
            n_checks++;
            if (o_stall !== e_stall) begin
                n_fail++; $display("FAIL rand_stall[%0d]: got %b required %b", i, o_stall, e_stall);
            end
            n_checks++;
            if (o_A !== e_a || o_B !== e_b || o_store_data !== e_sd) begin
                n_fail++; $display("FAIL rand_operands[%0d]: A=%h B=%h sd=%h required %h/%h/%h",
                    i, o_A, o_B, o_store_data, e_a, e_b, e_sd);
            end
            n_checks++;
            if ({o_valid, o_ALUctrl, o_rd, o_regwrite, o_memread} !== {m.v, m.op, m.d, m.rw, m.mr}) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got %h required %h", i,
                    {o_valid, o_ALUctrl, o_rd, o_regwrite, o_memread}, {m.v, m.op, m.d, m.rw, m.mr});
            end
            if (flush || e_stall)
                m = '0;
            else
                m = '{v: valid, op: alu, s1: rs1, s2: rs2, d: rd, r1: rdata1, r2: rdata2,
                      im: imm, ui: use_imm, rw: regwrite & valid, mr: memread & valid};
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_plain_pass();
        test_forward();
        test_load_use();
        test_flush();
        test_raw_ex();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
